// File: rtl/rv32i_dmem_responder.sv
// rtl/rv32i_dmem_responder.sv - rv32i data-side responder: lane-write RAM, cycle/TX/STATUS/GPIO MMIO window (optional DMEM_FAULT_EN adds fault port)
module rv32i_dmem_responder #(
    parameter int          DATA_WIDTH = 32,
    parameter int          RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          TX_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           daddr,
    input  logic [DATA_WIDTH-1:0] ddout,
    input  logic                  dwe0,
    input  logic                  dwe1,
    input  logic                  dwe2,
    output logic [DATA_WIDTH-1:0] ddin,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] gpio_out
`ifdef DMEM_FAULT_EN
    ,
    output logic                  fault
`endif
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
    logic [7:0]            fifo_mem [TX_DEPTH];

    logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
    logic [DATA_WIDTH-1:0] gpio_q, gpio_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [2:0]            size_code;
    logic                  is_store;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mmio_sel;
    logic [1:0]            mmio_off;
    logic                  store_ok;
    logic                  ram_we, tx_push, status_wr, gpio_wr;
    logic                  full, pop, push_acc, push_drop;
    logic [DATA_WIDTH-1:0] rd_word, mmio_word;
    logic [AW-1:0]         ram_idx;

    assign size_code = {dwe0, dwe1, dwe2};
    assign mmio_sel  = (daddr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off  = daddr[3:2];
    assign ram_idx   = daddr[2 +: AW];

    // Decode store size into byte enables (bit i covers word bits [8i+7:8i]) and lane-replicated data
    always_comb begin
        is_store = 1'b0;
        be       = 4'b0000;
        wdata    = ddout;
        case (size_code)
            3'b100: begin
                is_store = 1'b1;
                be       = 4'b1000 >> daddr[1:0];
                wdata    = {4{ddout[31:24]}};
            end
            3'b110: begin
                is_store = 1'b1;
                be       = daddr[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{ddout[31:16]}};
            end
            3'b111: begin
                is_store = 1'b1;
                be       = 4'b1111;
            end
            default: ;
        endcase
    end

`ifdef DMEM_FAULT_EN
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    logic fault_q, fault_d;
    logic in_ram, addr_bad, size_illegal;

    assign in_ram       = ({1'b0, daddr} < RAM_BYTES);
    assign addr_bad     = !mmio_sel && !in_ram;
    assign size_illegal = (size_code != 3'b000) && !is_store;
    assign store_ok     = is_store && !addr_bad && !rst;
    assign fault        = fault_q;

    // Sticky fault on out-of-window stores or illegal size codes
    always_comb begin
        fault_d = fault_q | (dwe0 & addr_bad) | size_illegal;
    end

    // Fault register
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end
`else
    assign store_ok = is_store && !rst;
`endif

    assign ram_we    = store_ok && !mmio_sel;
    assign tx_push   = store_ok && mmio_sel && (mmio_off == 2'd1);
    assign status_wr = store_ok && mmio_sel && (mmio_off == 2'd2);
    assign gpio_wr   = store_ok && mmio_sel && (mmio_off == 2'd3);

    // RAM lane writes
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Next state for counter, GPIO, FIFO pointers and overflow flag
    always_comb begin
        cycle_d   = cycle_q + 1'b1;
        gpio_d    = gpio_q;
        for (int i = 0; i < 4; i++) begin
            if (gpio_wr && be[i]) gpio_d[8*i +: 8] = wdata[8*i +: 8];
        end
        full      = (count_q == CW'(TX_DEPTH));
        pop       = tx_valid && tx_ready;
        push_acc  = tx_push && !full;
        push_drop = tx_push && full;
        rd_d      = rd_q + PW'(pop);
        wr_d      = wr_q + PW'(push_acc);
        count_d   = count_q + CW'(push_acc) - CW'(pop);
        ovf_d     = ovf_q;
        if (status_wr) ovf_d = 1'b0;
        if (push_drop) ovf_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            gpio_q  <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            gpio_q  <= gpio_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_q] <= ddout[31:24];
    end

    assign tx_valid = (count_q != '0);
    assign tx_data  = tx_valid ? fifo_mem[rd_q] : 8'h00;
    assign gpio_out = gpio_q;

    // Load path: select word, then rotate left by the byte offset
    always_comb begin
        mmio_word = '0;
        case (mmio_off)
            2'd0: mmio_word = cycle_q;
            2'd1: mmio_word = '0;
            2'd2: mmio_word = {ovf_q, 19'b0, 12'(count_q)};
            2'd3: mmio_word = gpio_q;
            default: ;
        endcase
        rd_word = mmio_sel ? mmio_word : mem[ram_idx];
        case (daddr[1:0])
            2'd0: ddin = rd_word;
            2'd1: ddin = {rd_word[23:0], rd_word[31:24]};
            2'd2: ddin = {rd_word[15:0], rd_word[31:16]};
            default: ddin = {rd_word[7:0], rd_word[31:8]};
        endcase
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb/tb_rv32i_dmem_responder.sv - randomized bench for rv32i_dmem_responder against a byte-level model
module tb_rv32i_dmem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] daddr = '0;
    logic [31:0] ddout = '0;
    logic        dwe0 = 1'b0, dwe1 = 1'b0, dwe2 = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] ddin;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] gpio_out;
`ifdef DMEM_FAULT_EN
    logic        fault;
`endif

    rv32i_dmem_responder dut (
        .clk(clk), .rst(rst), .daddr(daddr), .ddout(ddout),
        .dwe0(dwe0), .dwe1(dwe1), .dwe2(dwe2), .ddin(ddin),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gpio_out(gpio_out)
`ifdef DMEM_FAULT_EN
        , .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  ram_m [1024][4];
    logic [31:0] cyc_m  = '0;
    logic [31:0] gpio_m = '0;
    logic        ovf_m  = 1'b0;
    logic        fault_m = 1'b0;
    logic [7:0]  q_m [$];

    logic [31:0] last_ddin;
    logic [7:0]  last_txd;
    logic        last_txv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic is_mmio(input logic [31:0] a);
        return a[31:4] == MB[31:4];
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [7:0]  b [4];
        logic [31:0] w;
        int k;
        k = int'(a[1:0]);
        if (is_mmio(a)) begin
            case (a[3:2])
                2'd0: w = cyc_m;
                2'd1: w = 32'h0;
                2'd2: w = {ovf_m, 19'b0, 12'(q_m.size())};
                default: w = gpio_m;
            endcase
            for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = ram_m[a[11:2]][i];
        end
        return {b[k], b[(k+1)%4], b[(k+2)%4], b[(k+3)%4]};
    endfunction

    // Apply one clock edge worth of behaviour to the model (pre-edge inputs)
    task automatic model_update(input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] code, input logic rdy, input logic r);
        int offs [$];
        logic [7:0] vals [$];
        logic legal, ok, full;
        if (r) begin
            cyc_m = '0; gpio_m = '0; ovf_m = 1'b0; fault_m = 1'b0;
            q_m.delete();
            return;
        end
        cyc_m = cyc_m + 1;
        legal = (code == 3'b100) || (code == 3'b110) || (code == 3'b111);
        ok = legal;
`ifdef DMEM_FAULT_EN
        begin
            logic bad;
            bad = !is_mmio(a) && (a >= 32'd4096);
            if ((code != 3'b000) && !legal) fault_m = 1'b1;
            if (code[2] && bad) fault_m = 1'b1;
            if (bad) ok = 1'b0;
        end
`endif
        if (code == 3'b100) begin
            offs.push_back(int'(a[1:0])); vals.push_back(d[31:24]);
        end else if (code == 3'b110) begin
            offs.push_back(2*int'(a[1]));   vals.push_back(d[31:24]);
            offs.push_back(2*int'(a[1])+1); vals.push_back(d[23:16]);
        end else if (code == 3'b111) begin
            for (int i = 0; i < 4; i++) begin
                offs.push_back(i); vals.push_back(d[31-8*i -: 8]);
            end
        end
        full = (q_m.size() == 8);
        if (rdy && q_m.size() != 0) void'(q_m.pop_front());
        if (ok && is_mmio(a)) begin
            case (a[3:2])
                2'd1: if (full) ovf_m = 1'b1; else q_m.push_back(d[31:24]);
                2'd2: ovf_m = 1'b0;
                2'd3: for (int i = 0; i < offs.size(); i++) gpio_m[31-8*offs[i] -: 8] = vals[i];
                default: ;
            endcase
        end else if (ok) begin
            for (int i = 0; i < offs.size(); i++) ram_m[a[11:2]][offs[i]] = vals[i];
        end
    endtask

    // chk: 0 = no checks, 1 = all but ddin, 2 = all
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [2:0] code,
                        input logic rdy, input logic r, input int chk);
        daddr = a; ddout = d; {dwe0, dwe1, dwe2} = code; tx_ready = rdy; rst = r;
        #1;
        last_ddin = ddin;
        last_txd  = tx_data;
        last_txv  = tx_valid;
        if (chk == 2) check_eq("ddin", ddin, model_rd(a));
        if (chk >= 1) begin
            check_eq("tx_valid", {31'b0, tx_valid}, {31'b0, q_m.size() != 0});
            check_eq("tx_data", {24'b0, tx_data}, q_m.size() != 0 ? {24'b0, q_m[0]} : 32'h0);
            check_eq("gpio_out", gpio_out, gpio_m);
`ifdef DMEM_FAULT_EN
            check_eq("fault", {31'b0, fault}, {31'b0, fault_m});
`endif
        end
        @(posedge clk);
        model_update(a, d, code, rdy, r);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset held two cycles
        step(MB, 0, 3'b000, 1'b0, 1'b1, 0);
        step(MB, 0, 3'b000, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            step(MB, 0, 3'b000, 1'b0, 1'b0, 2);
            check_eq("cycle_seq", last_ddin, 32'(i));
            if (i == 0) check_eq("rst_txv", {31'b0, last_txv}, 32'h0);
        end
        step(MB + 8, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("rst_status", last_ddin, 32'h0);

        // word then byte store
        step(32'h10, 32'h1122_3344, 3'b111, 1'b0, 1'b0, 1);
        step(32'h10, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("sw_rd", last_ddin, 32'h1122_3344);
        step(32'h12, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("sw_rd_rot", {16'h0, last_ddin[31:16]}, 32'h3344);
        step(32'h11, 32'hAB00_0000, 3'b100, 1'b0, 1'b0, 1);
        step(32'h10, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("sb_word", last_ddin, 32'h11AB_3344);
        step(32'h11, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("sb_rd", {24'h0, last_ddin[31:24]}, 32'hAB);
        step(32'h16, 32'hBEEF_0000, 3'b110, 1'b0, 1'b0, 1);
        step(32'h14, 0, 3'b000, 1'b0, 1'b0, 1);
        check_eq("sh_lane", {16'h0, last_ddin[15:0]}, 32'hBEEF);

        // FIFO overflow then drain
        for (int i = 1; i <= 9; i++) step(MB + 4, {8'(i), 24'h0}, 3'b100, 1'b0, 1'b0, 2);
        step(MB + 8, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("status_full", last_ddin, 32'h8000_0008);
        for (int i = 1; i <= 8; i++) begin
            step(MB, 0, 3'b000, 1'b1, 1'b0, 2);
            check_eq("drain", {24'h0, last_txd}, 32'(i));
        end
        step(MB, 0, 3'b000, 1'b1, 1'b0, 2);
        check_eq("drained", {31'b0, last_txv}, 32'h0);
        step(MB + 8, 32'h0, 3'b111, 1'b0, 1'b0, 2);
        step(MB + 8, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("ovf_clear", last_ddin, 32'h0);

        // simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) step(MB + 4, {8'(8'h21 + i), 24'h0}, 3'b100, 1'b0, 1'b0, 2);
        step(MB + 4, 32'h2400_0000, 3'b100, 1'b1, 1'b0, 2);
        step(MB + 8, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("pushpop_cnt", last_ddin, 32'h3);
        for (int i = 0; i < 3; i++) begin
            step(MB, 0, 3'b000, 1'b1, 1'b0, 2);
            check_eq("pushpop_order", {24'h0, last_txd}, 32'(8'h22 + i));
        end

        // GPIO word then byte lane
        step(MB + 12, 32'hDEAD_BEEF, 3'b111, 1'b0, 1'b0, 2);
        step(MB + 13, 32'h5A00_0000, 3'b100, 1'b0, 1'b0, 2);
        step(MB + 12, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("gpio_lane", last_ddin, 32'hDE5A_BEEF);

        // cycle counter wrap
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        cyc_m = 32'hFFFF_FFFF;
        step(MB, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("cyc_max", last_ddin, 32'hFFFF_FFFF);
        step(MB, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("cyc_wrap", last_ddin, 32'h0);

        // initialise RAM words 0..15
        for (int i = 0; i < 16; i++) step(32'(4*i), $urandom, 3'b111, 1'b0, 1'b0, 1);

`ifdef DMEM_FAULT_EN
        step(32'h0001_0000, 32'hCAFE_F00D, 3'b111, 1'b0, 1'b0, 2);
        step(32'h0, 0, 3'b000, 1'b0, 1'b0, 2);
        check_eq("fault_set", {31'b0, fault}, 32'h1);
        check_eq("fault_ram0", last_ddin, {ram_m[0][0], ram_m[0][1], ram_m[0][2], ram_m[0][3]});
`endif

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [2:0]  code;
            int reg_sel;
            reg_sel = $urandom_range(0, 9);
            if (reg_sel <= 5)      a = 32'($urandom_range(0, 63));
            else if (reg_sel <= 8) a = MB + 32'($urandom_range(0, 15));
            else                   a = 32'h1000 * 32'($urandom_range(1, 15)) + 32'($urandom_range(0, 63));
            case ($urandom_range(0, 15))
                0:       code = 3'($urandom);
                1, 2, 3: code = 3'b100;
                4, 5:    code = 3'b110;
                6, 7, 8: code = 3'b111;
                default: code = 3'b000;
            endcase
            step(a, $urandom, code, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
